// File: rtl/io_port_ctrl.sv
// io_port_ctrl: CPU-mapped IO port. It has a 4-deep TX FIFO (written at BASE),
// a one-word RX holding register (read at BASE) and a status word (read at BASE+1).
module io_port_ctrl #(
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] bus_in,
  input  logic        DI,
  input  logic        DO,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [15:0] STAT_ADDR = BASE + 16'd1;

  logic [15:0] fifo_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        rx_full_q, rx_full_d;
  logic [15:0] rx_hold_q, rx_hold_d;
  logic        ovf_q, ovf_d;

  logic wr_cyc, rd_cyc, push_req, data_rd, stat_rd;
  logic tx_empty, tx_full, pop, push, ovf_evt, capture;

  // DI wins over DO, so a read cycle needs DI low.
  assign wr_cyc   = DI;
  assign rd_cyc   = DO & ~DI;
  assign push_req = wr_cyc & (addr == BASE);
  assign data_rd  = rd_cyc & (addr == BASE);
  assign stat_rd  = rd_cyc & (addr == STAT_ADDR);

  assign tx_empty = (count_q == 3'd0);
  assign tx_full  = (count_q == 3'd4);
  assign tx_valid = ~tx_empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign rx_ready = ~rx_full_q;

  // A pop in the same cycle makes room, so a full FIFO can still accept a push.
  assign pop      = tx_valid & tx_ready;
  assign push     = push_req & (~tx_full | pop);
  assign ovf_evt  = push_req & tx_full & ~pop;
  // rx_ready is low while full, so capture and a clearing data read never overlap.
  assign capture  = rx_valid & ~rx_full_q;

  // Next-state for pointers, occupancy, RX holding register and sticky overflow.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    ovf_d     = ovf_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
    if (data_rd && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (capture) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end
    // An overflow in the same cycle as a status read keeps the flag set.
    if (ovf_evt)      ovf_d = 1'b1;
    else if (stat_rd) ovf_d = 1'b0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      rx_full_q <= 1'b0;
      rx_hold_q <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage is left uninitialised; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= bus_in;
  end

  // Read mux, combinational from the bus controls with zero latency.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = 16'h0000;
    if (data_rd) begin
      bus_oe  = 1'b1;
      bus_out = rx_full_q ? rx_hold_q : 16'h0000;
    end else if (stat_rd) begin
      bus_oe  = 1'b1;
      bus_out = {12'b0, ovf_q, rx_full_q, tx_empty, tx_full};
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_io_port_ctrl;

  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [15:0] STAT = BASE + 16'd1;

  logic        clk = 1'b0;
  logic        reset, DI, DO, tx_ready, rx_valid;
  logic [15:0] addr, bus_in, rx_data;
  logic [15:0] bus_out, tx_data;
  logic        bus_oe, tx_valid, rx_ready;

  int tot = 0;
  int bad = 0;

  // reference model state
  logic [15:0] mq[$];
  bit          m_rxf;
  logic [15:0] m_hold;
  bit          m_ovf;

  io_port_ctrl #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .bus_in(bus_in), .DI(DI), .DO(DO),
    .bus_out(bus_out), .bus_oe(bus_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_status();
    return {12'b0, m_ovf, m_rxf, mq.size() == 0, mq.size() == 4};
  endfunction

  // Apply inputs on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic di, input logic dov,
                       input logic [15:0] a, input logic [15:0] bi,
                       input logic txr, input logic rxv, input logic [15:0] rxd);
    @(negedge clk);
    reset = r; DI = di; DO = dov; addr = a; bus_in = bi;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  // Advance through the rising edge and apply the behavioural rules to the model.
  task automatic tick();
    bit pop, preq, rd, st, full0;
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_rxf = 0; m_hold = 16'h0000; m_ovf = 0;
    end else begin
      pop   = (mq.size() != 0) && tx_ready;
      preq  = DI && addr == BASE;
      rd    = !DI && DO && addr == BASE;
      st    = !DI && DO && addr == STAT;
      full0 = (mq.size() == 4);
      if (preq && full0 && !pop) m_ovf = 1;
      else if (st)               m_ovf = 0;
      if (pop) void'(mq.pop_front());
      if (preq && (!full0 || pop)) mq.push_back(bus_in);
      if (rd && m_rxf) m_rxf = 0;
      else if (rx_valid && !m_rxf) begin m_rxf = 1; m_hold = rx_data; end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, BASE, 16'hDEAD, 1'b1, 1'b1, 16'hBEEF);
    tick();
    idle();
    tot++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%0h exp=0", tx_valid); end
    tot++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%0h exp=1", rx_ready); end
    tot++; if (bus_oe !== 1'b0 || bus_out !== 16'h0) begin bad++; $display("FAIL rst_bus got oe=%0h out=%h exp 0/0000", bus_oe, bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_oe !== 1'b1 || bus_out !== 16'h0002) begin bad++; $display("FAIL rst_status got oe=%0h out=%h exp 1/0002", bus_oe, bus_out); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, BASE, 16'(i), 1'b0, 1'b0, 16'h0);
      tick();
    end
    idle();
    tot++; if (tx_valid !== 1'b1 || tx_data !== 16'h0001) begin bad++; $display("FAIL fill_head got v=%0h d=%h exp 1/0001", tx_valid, tx_data); end
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h0001) begin bad++; $display("FAIL fill_status got=%h exp=0001", bus_out); end
    tick();
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 1'b0, BASE, 16'h0005, 1'b0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h0009) begin bad++; $display("FAIL ovf_status got=%h exp=0009", bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h0001) begin bad++; $display("FAIL ovf_cleared got=%h exp=0001", bus_out); end
    tick();
    idle();
    tot++; if (tx_data !== 16'h0001) begin bad++; $display("FAIL ovf_head_kept got=%h exp=0001", tx_data); end
    tick();
  endtask

  task automatic test_push_pop_full();
    logic [15:0] exp_seq [4];
    exp_seq = '{16'h0002, 16'h0003, 16'h0004, 16'h0005};
    drive(1'b0, 1'b1, 1'b0, BASE, 16'h0005, 1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h0001) begin bad++; $display("FAIL pp_full_status got=%h exp=0001", bus_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
      tot++; if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin bad++; $display("FAIL pp_pop%0d got v=%0h d=%h exp 1/%h", i, tx_valid, tx_data, exp_seq[i]); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (tx_valid !== 1'b0 || bus_out !== 16'h0002) begin bad++; $display("FAIL pp_drained got v=%0h st=%h exp 0/0002", tx_valid, bus_out); end
    tick();
  endtask

  task automatic test_rx();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h1234);
    tot++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_pre got=%0h exp=1", rx_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b1, 16'h9999);
    tot++; if (rx_ready !== 1'b0 || bus_out !== 16'h0006) begin bad++; $display("FAIL rx_full got rdy=%0h st=%h exp 0/0006", rx_ready, bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, BASE, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_oe !== 1'b1 || bus_out !== 16'h1234) begin bad++; $display("FAIL rx_read got oe=%0h out=%h exp 1/1234", bus_oe, bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, BASE, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (rx_ready !== 1'b1 || bus_out !== 16'h0000) begin bad++; $display("FAIL rx_empty_read got rdy=%0h out=%h exp 1/0000", rx_ready, bus_out); end
    tick();
  endtask

  task automatic test_di_do();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h5555);
    tick();
    drive(1'b0, 1'b1, 1'b1, BASE, 16'h00AA, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_oe !== 1'b0 || bus_out !== 16'h0000) begin bad++; $display("FAIL dido_bus got oe=%0h out=%h exp 0/0000", bus_oe, bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (tx_data !== 16'h00AA || bus_out !== 16'h0004) begin bad++; $display("FAIL dido_state got d=%h st=%h exp 00AA/0004", tx_data, bus_out); end
    tick();
    drive(1'b0, 1'b0, 1'b1, BASE, 16'h0, 1'b1, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h5555) begin bad++; $display("FAIL dido_rx_kept got=%h exp=5555", bus_out); end
    tick();
  endtask

  task automatic test_other_addr();
    drive(1'b0, 1'b1, 1'b0, STAT, 16'h7777, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_oe !== 1'b0) begin bad++; $display("FAIL oth_wr_stat_oe got=%0h exp=0", bus_oe); end
    tick();
    drive(1'b0, 1'b0, 1'b1, BASE + 16'd2, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_oe !== 1'b0 || bus_out !== 16'h0) begin bad++; $display("FAIL oth_rd_oe got oe=%0h out=%h exp 0/0000", bus_oe, bus_out); end
    tick();
    drive(1'b0, 1'b1, 1'b0, BASE - 16'd1, 16'h1111, 1'b0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, STAT, 16'h0, 1'b0, 1'b0, 16'h0);
    tot++; if (bus_out !== 16'h0002 || tx_valid !== 1'b0) begin bad++; $display("FAIL oth_no_effect got st=%h v=%0h exp 0002/0", bus_out, tx_valid); end
    tick();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, BASE, 16'hA000 + 16'(i), 1'b0, 1'b0, 16'h0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    idle();
    tot++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mrst_tx_valid got=%0h exp=0", tx_valid); end
    tick();
    drive(1'b0, 1'b1, 1'b0, BASE, 16'h0BEE, 1'b0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
    tot++; if (tx_valid !== 1'b1 || tx_data !== 16'h0BEE) begin bad++; $display("FAIL mrst_first got v=%0h d=%h exp 1/0BEE", tx_valid, tx_data); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a, eo;
    logic        di, dov, eoe;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = BASE;
        2:       a = STAT;
        default: a = 16'($urandom);
      endcase
      di  = ($urandom_range(0, 2) == 0);
      dov = ($urandom_range(0, 1) == 0);
      drive(($urandom_range(0, 60) == 0), di, dov, a, 16'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), 16'($urandom));
      eoe = !di && dov && (a == BASE || a == STAT);
      eo  = !eoe ? 16'h0 : (a == BASE) ? (m_rxf ? m_hold : 16'h0) : m_status();
      tot++; if (bus_oe !== eoe || bus_out !== eo) begin bad++; $display("FAIL rnd_bus n=%0d got oe=%0h out=%h exp %0h/%h", n, bus_oe, bus_out, eoe, eo); end
      tot++; if (tx_valid !== (mq.size() != 0) || rx_ready !== !m_rxf) begin bad++; $display("FAIL rnd_flags n=%0d got txv=%0h rxr=%0h exp %0h/%0h", n, tx_valid, rx_ready, mq.size() != 0, !m_rxf); end
      if (mq.size() != 0) begin
        tot++; if (tx_data !== mq[0]) begin bad++; $display("FAIL rnd_tx_data n=%0d got=%h exp=%h", n, tx_data, mq[0]); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; DI = 1'b0; DO = 1'b0; addr = 16'h0; bus_in = 16'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    test_reset();
    test_fill();
    test_overflow();
    test_push_pop_full();
    test_rx();
    test_di_do();
    test_other_addr();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter: BASE, 16'h0000, device address of the data port; the status port is at BASE+1.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: addr  input  16  CPU address bus.
REQ-005 Port: bus_in  input  16  CPU bus value, valid while DI is high.
REQ-006 Port: DI  input  1  CPU writing to a device this cycle.
REQ-007 Port: DO  input  1  CPU reading from a device this cycle.
REQ-008 Port: bus_out  output  16  value driven to the CPU bus.
REQ-009 Port: bus_oe  output  1  high when bus_out must drive the CPU bus.
REQ-010 Port: tx_data  output  16  head word of the TX FIFO.
REQ-011 Port: tx_valid  output  1  TX FIFO is non-empty.
REQ-012 Port: tx_ready  input  1  sink accepts tx_data this cycle.
REQ-013 Port: rx_data  input  16  word from the source.
REQ-014 Port: rx_valid  input  1  rx_data is valid.
REQ-015 Port: rx_ready  output  1  RX holding register is empty.

Function
REQ-016 Decode: a write cycle is DI=1; a read cycle is DO=1 and DI=0. DI has priority, so DO is ignored whenever DI=1.
REQ-017 TX FIFO: 4 entries x 16 bits; 2-bit read/write pointers wrap 3->0; 3-bit count in the range 0..4.
REQ-018 A write cycle with addr==BASE pushes bus_in at the next edge, provided count<4 or a pop occurs in the same cycle.
REQ-019 A push to a full FIFO with no pop in the same cycle drops the data, leaves the FIFO unchanged, and sets the sticky overflow flag.
REQ-020 tx_valid = (count!=0); tx_data = entry[rd_ptr], combinational from registers.
REQ-021 A pop occurs when tx_valid && tx_ready, and advances rd_ptr.
REQ-022 Simultaneous push and pop: both pointers advance and count is unchanged, including when count=4 (no overflow) and count=0 is impossible for a pop.
REQ-023 RX holding register: rx_ready = !rx_full. When rx_valid && rx_ready, rx_data is captured and rx_full is set.
REQ-024 A read cycle with addr==BASE drives bus_oe=1 and bus_out=rx_hold if rx_full, else 16'h0000. It clears rx_full at the edge only if rx_full was set.
REQ-025 A read cycle with addr==BASE+1 drives bus_oe=1 and bus_out = {12'b0, overflow, rx_full, tx_empty, tx_full}.
REQ-026 A status read clears overflow at the edge. If an overflow event occurs in the same cycle, overflow stays set and the returned value shows the pre-edge flag.
REQ-027 Because rx_ready is low while rx_full=1, a CPU data read and an RX capture never collide. Capture into a just-emptied register occurs on the following cycle at the earliest.
REQ-028 bus_oe is combinational from DI, DO and addr with zero latency. bus_oe=0 and bus_out=16'h0000 for every other address and whenever DI=1.
REQ-029 Write cycles to BASE+1 and writes or reads to other addresses have no effect on state.
REQ-030 Push/pop latency: a word pushed at edge N appears on tx_data/tx_valid after edge N when the FIFO was empty.

Reset
REQ-031 reset=1 at an edge clears pointers, count, rx_full and overflow and zeroes rx_hold. FIFO contents need not be cleared.
REQ-032 While reset=1 no push, pop or capture takes effect, even with DI, tx_ready or rx_valid asserted.
REQ-033 Post-reset output values: tx_valid=0, rx_ready=1, bus_oe=0 with DI=DO=0, and status=16'h0002.
REQ-034 A reset asserted mid-operation with the FIFO partly full discards all queued words. The first post-reset push appears at tx_data.

Verification
REQ-035 Reset, then write 0x0001..0x0004 to BASE with tx_ready=0 -> tx_valid=1, tx_data=0x0001, status=0x0001.
REQ-036 Continue with a fifth write of 0x0005 -> dropped and status=0x0009; a second status read -> 0x0001 (overflow cleared).
REQ-037 Full FIFO, write 0x0005 with tx_ready=1 in the same cycle -> no overflow; subsequent pops yield 0x0002, 0x0003, 0x0004, 0x0005 in order.
REQ-038 rx_valid with rx_data=0x1234 -> rx_ready falls next cycle and status bit2=1; read BASE -> bus_out=0x1234 then rx_ready=1; read BASE again -> 0x0000.
REQ-039 DI=1 and DO=1 together at addr BASE with bus_in=0x00AA -> push of 0x00AA, bus_oe=0, rx_full unchanged.
REQ-040 Reset pulsed with 3 words queued -> tx_valid=0; a following write of 0x0BEE -> tx_data=0x0BEE.
